// File: rtl/kf6845_config_sequencer.sv
// kf6845_config_sequencer: loads KF6845 registers from a config table and arbitrates the CRTC bus with the host
// Ports: clock/reset (async, active-high); start pulse; config_table byte i -> Ri;
//   host_* bus from CPU glue; crtc_* bus to the KF6845; host_wait/busy/done status.
// Optional macro KF6845_CONFIG_READBACK_EN adds crtc_q input, verify_error output and R14/R15 readback.
module kf6845_config_sequencer #(
  parameter int REG_COUNT     = 16,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 2
) (
`ifdef KF6845_CONFIG_READBACK_EN
  input  logic [7:0]             crtc_q,
  output logic                   verify_error,
`endif
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*REG_COUNT-1:0] config_table,
  input  logic                   host_cs_n,
  input  logic                   host_rs,
  input  logic                   host_enable,
  input  logic                   host_r_or_w,
  input  logic [7:0]             host_d,
  output logic                   crtc_cs_n,
  output logic                   crtc_rs,
  output logic                   crtc_enable,
  output logic                   crtc_r_or_w,
  output logic [7:0]             crtc_d,
  output logic                   host_wait,
  output logic                   busy,
  output logic                   done
);
  localparam int MAXC = (SETUP_CYCLES > STROBE_CYCLES) ?
    ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
    ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  typedef enum logic [1:0] {ADDR, DATA, READ} phase_t;
  state_t state, state_n;
  phase_t phase, phase_n;
  logic [4:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic pending, pending_n, done_n, accept, last, seq;
  logic [7:0] tbl_byte;
`ifdef KF6845_CONFIG_READBACK_EN
  logic rb, rb_n, mismatch;
`endif
  assign tbl_byte = config_table[8*idx +: 8];
  assign accept = (state == IDLE) && pending && !host_enable && host_cs_n;
  assign last = (cnt == '0);
  assign seq = (state != IDLE);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= ADDR;
      idx     <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      pending <= pending_n;
      done    <= done_n;
    end
  end
`ifdef KF6845_CONFIG_READBACK_EN
  // R14 is only 6 bits wide in the CRTC, so its upper bits read back as zero
  assign mismatch = (idx == 5'd14) ? (crtc_q[5:0] != tbl_byte[5:0]) : (crtc_q != tbl_byte);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rb           <= 1'b0;
      verify_error <= 1'b0;
    end else begin
      rb           <= rb_n;
      verify_error <= accept ? 1'b0 :
                      (state == STROBE && last && phase == READ && mismatch) ? 1'b1 : verify_error;
    end
  end
`endif
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    idx_n     = idx;
    cnt_n     = cnt;
    pending_n = pending;
    done_n    = 1'b0;
`ifdef KF6845_CONFIG_READBACK_EN
    rb_n      = rb;
`endif
    case (state)
      IDLE: begin
        pending_n = start ? 1'b1 : pending;
        if (accept) begin
          pending_n = 1'b0;
          idx_n     = '0;
          phase_n   = ADDR;
          state_n   = SETUP;
          cnt_n     = CW'(SETUP_CYCLES - 1);
`ifdef KF6845_CONFIG_READBACK_EN
          rb_n      = 1'b0;
`endif
        end
      end
      SETUP: begin
        state_n = last ? STROBE : SETUP;
        cnt_n   = last ? CW'(STROBE_CYCLES - 1) : cnt - 1'b1;
      end
      STROBE: begin
        state_n = last ? HOLD : STROBE;
        cnt_n   = last ? CW'(HOLD_CYCLES - 1) : cnt - 1'b1;
      end
      HOLD: begin
        cnt_n = last ? CW'(SETUP_CYCLES - 1) : cnt - 1'b1;
        if (last) begin
          state_n = SETUP;
          if (phase == ADDR) begin
`ifdef KF6845_CONFIG_READBACK_EN
            phase_n = rb ? READ : DATA;
`else
            phase_n = DATA;
`endif
          end else if (phase == DATA && idx != 5'(REG_COUNT - 1)) begin
            idx_n   = idx + 5'd1;
            phase_n = ADDR;
`ifdef KF6845_CONFIG_READBACK_EN
          end else if (phase == DATA) begin
            rb_n    = 1'b1;
            idx_n   = 5'd14;
            phase_n = ADDR;
          end else if (idx == 5'd14) begin
            idx_n   = 5'd15;
            phase_n = ADDR;
`endif
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy        = seq;
    host_wait   = seq;
    crtc_cs_n   = seq ? 1'b0 : host_cs_n;
    crtc_rs     = seq ? (phase != ADDR) : host_rs;
    crtc_enable = seq ? (state == STROBE) : host_enable;
    crtc_r_or_w = seq ? (phase == READ) : host_r_or_w;
    crtc_d      = seq ? ((phase == ADDR) ? {3'b0, idx} : tbl_byte) : host_d;
  end
endmodule

// File: tb/tb_kf6845_config_sequencer.sv
// tb_kf6845_config_sequencer: directed self-checking bench with a small 6845 register model
module tb_kf6845_config_sequencer;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [127:0] config_table;
  logic host_cs_n = 1'b1, host_rs = 1'b0, host_enable = 1'b0, host_r_or_w = 1'b1;
  logic [7:0] host_d = 8'h00;
  logic crtc_cs_n, crtc_rs, crtc_enable, crtc_r_or_w, host_wait, busy, done;
  logic [7:0] crtc_d;
  logic [7:0] regs [32];
  logic [4:0] addr = 5'd0;
  logic prev_en = 1'b0;
  int busy_cycles = 0, done_cnt = 0, strobe_cnt = 0;
  logic [7:0] s_d [1024];
  logic s_rs [1024];
  int n_tests = 0, n_fail = 0;
  logic [7:0] tv [16] = '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
                          8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef KF6845_CONFIG_READBACK_EN
  logic [7:0] crtc_q;
  logic verify_error;
  logic corrupt = 1'b0;
  assign crtc_q = (addr == 5'd14) ? (regs[14] & 8'h3F) : (regs[15] ^ {8{corrupt}});
`endif

  kf6845_config_sequencer dut (
`ifdef KF6845_CONFIG_READBACK_EN
    .crtc_q(crtc_q), .verify_error(verify_error),
`endif
    .clock(clock), .reset(reset), .start(start), .config_table(config_table),
    .host_cs_n(host_cs_n), .host_rs(host_rs), .host_enable(host_enable),
    .host_r_or_w(host_r_or_w), .host_d(host_d),
    .crtc_cs_n(crtc_cs_n), .crtc_rs(crtc_rs), .crtc_enable(crtc_enable),
    .crtc_r_or_w(crtc_r_or_w), .crtc_d(crtc_d),
    .host_wait(host_wait), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // monitors and CRTC model sample on the falling edge, away from DUT updates
  always @(negedge clock) begin
    if (busy) busy_cycles++;
    if (done) done_cnt++;
    if (crtc_enable && !prev_en && !crtc_cs_n) begin
      if (strobe_cnt < 1024) begin
        s_rs[strobe_cnt] = crtc_rs;
        s_d[strobe_cnt]  = crtc_d;
      end
      strobe_cnt++;
    end
    prev_en = crtc_enable;
    if (crtc_enable && !crtc_cs_n && !crtc_r_or_w) begin
      if (!crtc_rs) addr = crtc_d[4:0];
      else regs[addr] = crtc_d;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy && n < 50) begin
      tick();
      n++;
    end
    check(tag, busy, 1);
  endtask

  task automatic check_regs();
    for (int i = 0; i < 16; i++) check($sformatf("reg_r%0d", i), regs[i], tv[i]);
  endtask

  initial begin
    int b0, d0, s0;
    for (int i = 0; i < 32; i++) regs[i] = 8'h00;
    for (int i = 0; i < 16; i++) config_table[8*i +: 8] = tv[i];
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_host_wait", host_wait, 0);
    host_cs_n = 1'b0; host_rs = 1'b0; host_r_or_w = 1'b0; host_d = 8'h0C; host_enable = 1'b1;
    #1;
    check("pass_cs_n", crtc_cs_n, 0);
    check("pass_rs", crtc_rs, 0);
    check("pass_rw", crtc_r_or_w, 0);
    check("pass_en", crtc_enable, 1);
    check("pass_d", crtc_d, 8'h0C);
    tick(2);
    reset = 1'b0;
    host_enable = 1'b0;
    tick();
    host_cs_n = 1'b1; host_r_or_w = 1'b1;
    tick(2);

    b0 = busy_cycles; d0 = done_cnt; s0 = strobe_cnt;
    pulse_start();
    wait_busy("seq_busy_rise");
    check("seq_host_wait", host_wait, 1);
    wait_done("seq_done");
    tick(3);
    check("seq_busy_cycles", busy_cycles - b0, 160);
    check("seq_done_count", done_cnt - d0, 1);
    check("seq_strobes", strobe_cnt - s0, 32);
    check("strobe0_rs", s_rs[s0], 0);
    check("strobe0_d", s_d[s0], 8'h00);
    check("strobe1_rs", s_rs[s0+1], 1);
    check("strobe1_d", s_d[s0+1], 8'h71);
    check("strobe30_d", s_d[s0+30], 8'h0F);
    check("strobe31_rs", s_rs[s0+31], 1);
    check("strobe31_d", s_d[s0+31], tv[15]);
    check_regs();

    host_cs_n = 1'b0; host_rs = 1'b0; host_r_or_w = 1'b0; host_d = 8'h0E; host_enable = 1'b1;
    pulse_start();
    tick(4);
    check("hold_busy", busy, 0);
    check("hold_en_intact", crtc_enable, 1);
    check("hold_d_intact", crtc_d, 8'h0E);
    host_enable = 1'b0;
    tick(2);
    check("hold_cs_busy", busy, 0);
    host_cs_n = 1'b1; host_r_or_w = 1'b1;
    #1;
    check("hold_pre_accept", busy, 0);
    tick();
    check("hold_accepted", busy, 1);
    wait_done("hold_done");
    tick(2);

    host_d = 8'hA5;
    pulse_start();
    wait_busy("rst_mid_busy");
    tick(50);
    reset = 1'b1;
    #1;
    check("rst_mid_busy0", busy, 0);
    check("rst_mid_done0", done, 0);
    check("rst_mid_cs_n", crtc_cs_n, 1);
    check("rst_mid_en", crtc_enable, 0);
    check("rst_mid_d", crtc_d, 8'hA5);
    tick();
    reset = 1'b0;
    tick();
    b0 = busy_cycles; s0 = strobe_cnt;
    pulse_start();
    wait_done("reload_done");
    tick(2);
    check("reload_busy_cycles", busy_cycles - b0, 160);
    check("reload_first_d", s_d[s0], 8'h00);
    check("reload_first_rs", s_rs[s0], 0);
    check_regs();

    b0 = busy_cycles; d0 = done_cnt;
    pulse_start();
    wait_busy("ign_busy");
    tick(20);
    pulse_start();
    wait_done("ign_done");
    tick(10);
    check("ign_done_count", done_cnt - d0, 1);
    check("ign_busy_cycles", busy_cycles - b0, 160);

    b0 = busy_cycles; d0 = done_cnt;
    pulse_start();
    wait_done("chain_done1");
    pulse_start();
    tick();
    wait_done("chain_done2");
    tick(3);
    check("chain_done_count", done_cnt - d0, 2);
    check("chain_busy_cycles", busy_cycles - b0, 320);

`ifdef KF6845_CONFIG_READBACK_EN
    tv[14] = 8'hFF;
    tv[15] = 8'h12;
    config_table[8*14 +: 8] = tv[14];
    config_table[8*15 +: 8] = tv[15];
    b0 = busy_cycles;
    pulse_start();
    wait_done("rb_done");
    tick(2);
    check("rb_busy_cycles", busy_cycles - b0, 180);
    check("rb_no_error", verify_error, 0);
    check_regs();
    corrupt = 1'b1;
    pulse_start();
    wait_done("rb_bad_done");
    tick(5);
    check("rb_error_set", verify_error, 1);
    corrupt = 1'b0;
    pulse_start();
    check("rb_error_held", verify_error, 1);
    tick();
    check("rb_error_cleared", verify_error, 0);
    wait_done("rb_clean_done");
    tick(2);
    check("rb_clean_error", verify_error, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/kf6845_config_sequencer.md
Name: kf6845_config_sequencer

Overview:
- Drives the KF6845 processor interface (CS_N, RS, ENABLE, R_OR_W, data) to load registers R0..R(REG_COUNT-1) from a flat configuration table after a start request.
- Arbitrates the CRTC bus between this sequencer and the host CPU. The host owns the bus while the sequencer is idle.
- Sits between the system bus glue and the KF6845 top level.

Parameters:
- REG_COUNT, 16: number of registers loaded, R0 first; legal range 1..18.
- SETUP_CYCLES, 1: cycles the bus is valid with ENABLE low before the strobe; minimum 1.
- STROBE_CYCLES, 2: cycles ENABLE is held high; minimum 1.
- HOLD_CYCLES, 2: cycles the bus is held after ENABLE falls; minimum 2, because the CRTC samples the latched pins one cycle late.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle load request
- config_table  in  8*REG_COUNT  byte i = value for register Ri; must be held stable while busy
- host_cs_n  in  1  host chip select
- host_rs  in  1  host register select
- host_enable  in  1  host E strobe
- host_r_or_w  in  1  host read/write
- host_d  in  8  host write data
- crtc_cs_n  out  1  to CRTC CS_N
- crtc_rs  out  1  to CRTC RS
- crtc_enable  out  1  to CRTC ENABLE
- crtc_r_or_w  out  1  to CRTC R_OR_W
- crtc_d  out  8  to CRTC D_IN
- host_wait  out  1  high while the sequencer owns the bus
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset state: IDLE with pending=0, idx=0, phase=ADDR.
  - busy=0, done=0, host_wait=0.
  - crtc_* follow the host_* inputs.
- Bus mux:
  - In IDLE, crtc_* = host_* (combinational passthrough).
  - In any other state, crtc_* come from sequencer registers.
  - host_wait is high in every state except IDLE. Host inputs are ignored while host_wait is high.
- Start handling:
  - start high in IDLE sets pending.
  - start while busy is ignored.
- Acceptance:
  - Occurs in IDLE when pending=1, host_enable=0 and host_cs_n=1. An in-flight host cycle is never truncated.
  - On acceptance: clear pending, set idx=0 and phase=ADDR, go to SETUP, set busy=1.
- Each phase is SETUP (SETUP_CYCLES) -> STROBE (STROBE_CYCLES) -> HOLD (HOLD_CYCLES):
  - crtc_cs_n=0 and crtc_r_or_w=0 throughout.
  - crtc_enable=1 only in STROBE.
  - ADDR phase: crtc_rs=0, crtc_d={3'b0, idx}.
  - DATA phase: crtc_rs=1, crtc_d=config_table[8*idx +: 8].
- Transitions out of HOLD:
  - End of ADDR phase: go to phase=DATA, state SETUP.
  - End of DATA phase with idx<REG_COUNT-1: idx+1, phase=ADDR, state SETUP.
  - End of DATA phase with idx=REG_COUNT-1: go to IDLE, busy=0, done=1 for exactly one cycle.
- Counters:
  - One shared down-counter, width clog2(max(SETUP,STROBE,HOLD)+1).
  - idx is 5 bits and never exceeds REG_COUNT-1.
- Timing:
  - busy is high for exactly 2*REG_COUNT*(SETUP+STROBE+HOLD) cycles.
  - With defaults this is 160 cycles.
  - done coincides with the first IDLE cycle.
- Reset asserted mid-sequence returns immediately to IDLE. The bus reverts to host passthrough in the same cycle, and the partial load is abandoned.
- start asserted in the same cycle done fires sets pending, so a new sequence runs.

Optional Feature:
- Macro: KF6845_CONFIG_READBACK_EN.
- Defined:
  - Adds input crtc_q[7:0] (CRTC read data) and output verify_error.
  - After the final DATA phase, runs ADDR 14 -> READ -> ADDR 15 -> READ.
  - READ phase: crtc_rs=1, crtc_r_or_w=1, same SETUP/STROBE/HOLD timing.
  - crtc_q is sampled on the last STROBE cycle and compared against the table byte.
  - R14 compares bits [5:0]; R15 compares all 8 bits.
  - Any mismatch sets verify_error (sticky; cleared on next acceptance).
  - Adds 4*(S+E+H) cycles to busy.
  - REG_COUNT must be >=16.
- Undefined: no crtc_q port, no verify_error port, no readback phases.

Test Plan:
- Reset, then host write (cs_n=0, rs=0, d=0x0C, enable pulse) -> crtc_* mirror host_* combinationally; host_wait=0.
- Defaults, table R0=0x71..R15=0x00, start -> busy for 160 cycles.
  - First strobe has rs=0, d=0x00; second has rs=1, d=0x71.
  - The 32nd strobe has rs=1, d=table[15].
  - done pulses once.
  - A 6845 model's registers match the table.
- start while host_enable=1 -> sequencer waits; accepts the cycle after host_enable=0 and host_cs_n=1; host cycle completes intact.
- Reset asserted at cycle 50 of a sequence -> next cycle crtc_* = host_*, busy=0, done=0; new start reloads from R0.
- start pulsed at cycle 20 of a sequence -> ignored; exactly one done.
  - start pulsed in the done cycle -> second sequence runs.
- READBACK_EN defined, model returns 0x3F for R14 while table R14=0xFF -> no error.
  - Corrupt R15 readback -> verify_error=1 until next start.
